wfg_stim_sine_core: RTL and testbench



---
 rtl/wfg_stim_sine_pkg.sv | 71 +++++++
 rtl/wfg_stim_sine_cordic_step.sv | 37 +++
 rtl/wfg_stim_sine_core.sv | 163 ++++++++++++++++
 tb/tb_wfg_stim_sine_core.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wfg_stim_sine_pkg.sv
// Shared types and constants for the sine stimulus engine: CORDIC constants,
// FSM state encoding, phase folding and output saturation helpers.
package wfg_stim_sine_pkg;

  localparam int ZW      = 20;
  localparam int OUTW_C  = 18;
  localparam int PRODW   = 37;

  localparam logic signed [ZW-1:0] CORDIC_K_INIT = 20'sh09B75;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    SCALE = 2'd2,
    VALID = 2'd3
  } state_e;

  typedef struct packed {
    logic                 neg;
    logic signed [ZW-1:0] z;
  } fold_t;

  // atan(2^-i) in units of 2^-20 turn
  function automatic logic signed [ZW-1:0] atan_tab(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_tab = 20'sd131072;
      4'd1:    atan_tab = 20'sd77376;
      4'd2:    atan_tab = 20'sd40884;
      4'd3:    atan_tab = 20'sd20753;
      4'd4:    atan_tab = 20'sd10417;
      4'd5:    atan_tab = 20'sd5213;
      4'd6:    atan_tab = 20'sd2607;
      4'd7:    atan_tab = 20'sd1304;
      4'd8:    atan_tab = 20'sd652;
      4'd9:    atan_tab = 20'sd326;
      4'd10:   atan_tab = 20'sd163;
      4'd11:   atan_tab = 20'sd81;
      4'd12:   atan_tab = 20'sd41;
      4'd13:   atan_tab = 20'sd20;
      4'd14:   atan_tab = 20'sd10;
      4'd15:   atan_tab = 20'sd5;
      default: atan_tab = 20'sd0;
    endcase
  endfunction

  // Quadrants 1 and 2 are rotated by half a turn so CORDIC stays in range
  function automatic fold_t fold_phase(input logic [15:0] ph);
    fold_t       f;
    logic [15:0] t;
    if (ph[15:14] == 2'b01 || ph[15:14] == 2'b10) begin
      t     = ph - 16'h8000;
      f.neg = 1'b1;
    end else begin
      t     = ph;
      f.neg = 1'b0;
    end
    f.z = {t, 4'h0};
    return f;
  endfunction

  function automatic logic [OUTW_C-1:0] sat_out(input logic signed [PRODW-1:0] v);
    if (v > 37'sh1FFFF) begin
      sat_out = 18'h1FFFF;
    end else if (v < -37'sh20000) begin
      sat_out = 18'h20000;
    end else begin
      sat_out = v[OUTW_C-1:0];
    end
  endfunction

endpackage

// File: rtl/wfg_stim_sine_cordic_step.sv
// Single combinational CORDIC rotation in rotation mode, driving z toward zero.
module wfg_stim_sine_cordic_step
  import wfg_stim_sine_pkg::*;
(
  input  logic signed [ZW-1:0] x,
  input  logic signed [ZW-1:0] y,
  input  logic signed [ZW-1:0] z,
  input  logic        [3:0]    shift,
  input  logic signed [ZW-1:0] atan_val,
  output logic signed [ZW-1:0] x_nxt,
  output logic signed [ZW-1:0] y_nxt,
  output logic signed [ZW-1:0] z_nxt
);

  logic signed [ZW-1:0] x_sh_s;
  logic signed [ZW-1:0] y_sh_s;

  assign x_sh_s = x >>> shift;
  assign y_sh_s = y >>> shift;

  // Rotation direction from sign of residual angle; zero counts as positive
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    z_nxt = z;
    if (z[ZW-1] == 1'b0) begin
      x_nxt = x - y_sh_s;
      y_nxt = y + x_sh_s;
      z_nxt = z - atan_val;
    end else begin
      x_nxt = x + y_sh_s;
      y_nxt = y - x_sh_s;
      z_nxt = z + atan_val;
    end
  end

endmodule

// File: rtl/wfg_stim_sine_core.sv
// Sine sample engine: phase accumulator, iterative CORDIC, gain/offset scaling
// and an AXI-Stream master output.
module wfg_stim_sine_core
  import wfg_stim_sine_pkg::*;
#(
  parameter int ITER = 16,
  parameter int OUTW = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ctrl_en_q_i,
  input  logic [15:0]     inc_val_q_i,
  input  logic [15:0]     gain_val_q_i,
  input  logic [OUTW-1:0] offset_val_q_i,
  input  logic            wfg_axis_tready_i,
  output logic            wfg_axis_tvalid_o,
  output logic [OUTW-1:0] wfg_axis_tdata_o
);

  state_e               state_r, state_s;
  logic [15:0]          phase_r, phase_acc_s, cap_phase_s;
  logic                 load_s, last_iter_s;
  fold_t                fold_s;
  logic signed [ZW-1:0] x_r, y_r, z_r;
  logic signed [ZW-1:0] x_nxt_s, y_nxt_s, z_nxt_s;
  logic                 neg_r;
  logic [15:0]          gain_r;
  logic [OUTW-1:0]      offset_r;
  logic [3:0]           iter_r;
  logic signed [ZW-1:0]    s_s;
  logic signed [PRODW-1:0] s_ext_s, g_ext_s, prod_s, p_s, sum_s;
  logic                 tvalid_r;
  logic [OUTW-1:0]      tdata_r;

  assign phase_acc_s = phase_r + inc_val_q_i;
  assign last_iter_s = (iter_r == 4'(ITER - 1));
  assign fold_s      = fold_phase(cap_phase_s);

  wfg_stim_sine_cordic_step u_step (
    .x        (x_r),
    .y        (y_r),
    .z        (z_r),
    .shift    (iter_r),
    .atan_val (atan_tab(iter_r)),
    .x_nxt    (x_nxt_s),
    .y_nxt    (y_nxt_s),
    .z_nxt    (z_nxt_s)
  );

  // Next-state, sample-latch strobe and phase to latch
  always_comb begin
    state_s     = state_r;
    load_s      = 1'b0;
    cap_phase_s = 16'h0000;
    case (state_r)
      IDLE: begin
        if (ctrl_en_q_i) begin
          state_s = CALC;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (!ctrl_en_q_i) begin
          state_s = IDLE;
        end else if (last_iter_s) begin
          state_s = SCALE;
        end else begin
          state_s = CALC;
        end
      end
      SCALE: state_s = VALID;
      VALID: begin
        if (wfg_axis_tready_i) begin
          if (ctrl_en_q_i) begin
            state_s     = CALC;
            load_s      = 1'b1;
            cap_phase_s = phase_acc_s;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = VALID;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Sign restore and gain/offset arithmetic on the finished rotation
  always_comb begin
    if (neg_r) begin
      s_s = -y_r;
    end else begin
      s_s = y_r;
    end
    s_ext_s = {{(PRODW-ZW){s_s[ZW-1]}}, s_s};
    g_ext_s = {21'h000000, gain_r};
    prod_s  = s_ext_s * g_ext_s;
    p_s     = prod_s >>> 14;
    sum_s   = p_s + {{(PRODW-OUTW){offset_r[OUTW-1]}}, offset_r};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Working registers, phase accumulator and AXI-Stream output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r  <= 16'h0000;
      x_r      <= 20'sd0;
      y_r      <= 20'sd0;
      z_r      <= 20'sd0;
      neg_r    <= 1'b0;
      gain_r   <= 16'h0000;
      offset_r <= '0;
      iter_r   <= 4'd0;
      tvalid_r <= 1'b0;
      tdata_r  <= '0;
    end else begin
      if (load_s) begin
        x_r      <= CORDIC_K_INIT;
        y_r      <= 20'sd0;
        z_r      <= fold_s.z;
        neg_r    <= fold_s.neg;
        gain_r   <= gain_val_q_i;
        offset_r <= offset_val_q_i;
        iter_r   <= 4'd0;
      end else if (state_r == CALC && ctrl_en_q_i) begin
        x_r    <= x_nxt_s;
        y_r    <= y_nxt_s;
        z_r    <= z_nxt_s;
        iter_r <= iter_r + 4'd1;
      end
      case (state_r)
        IDLE:  phase_r <= 16'h0000;
        CALC:  ;
        SCALE: begin
          tdata_r  <= sat_out(sum_s);
          tvalid_r <= 1'b1;
        end
        VALID: begin
          if (wfg_axis_tready_i) begin
            tvalid_r <= 1'b0;
            phase_r  <= phase_acc_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign wfg_axis_tvalid_o = tvalid_r;
  assign wfg_axis_tdata_o  = tdata_r;

endmodule

// File: tb/tb_wfg_stim_sine_core.sv
// Directed self-checking bench for the sine sample engine.
module tb_wfg_stim_sine_core;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] inc;
  logic [15:0] gain;
  logic [17:0] offset;
  logic        tready;
  logic        tvalid;
  logic [17:0] tdata;

  int n_assert = 0;
  int n_fail   = 0;

  // sin(2*pi*k/16) * 65536
  int exp_sin [16] = '{0, 25080, 46341, 60547, 65536, 60547, 46341, 25080,
                       0, -25080, -46341, -60547, -65536, -60547, -46341, -25080};

  wfg_stim_sine_core dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ctrl_en_q_i       (en),
    .inc_val_q_i       (inc),
    .gain_val_q_i      (gain),
    .offset_val_q_i    (offset),
    .wfg_axis_tready_i (tready),
    .wfg_axis_tvalid_o (tvalid),
    .wfg_axis_tdata_o  (tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sdata();
    return 32'($signed(tdata));
  endfunction

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = obs - exp;
    if (d < 0) d = -d;
    n_assert++;
    assert ((d <= tol) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Advance negedge by negedge until tvalid is seen or the budget runs out
  task automatic wait_valid(input int budget, output int n, output int seen);
    n    = 0;
    seen = 0;
    while (seen == 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (tvalid) seen = 1;
    end
  endtask

  initial begin
    int n;
    int seen;
    int d0;

    rst_n  = 1'b0;
    en     = 1'b0;
    inc    = 16'h1000;
    gain   = 16'h4000;
    offset = 18'h00000;
    tready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset holds outputs low even with enable asserted
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("reset_tvalid", 32'(tvalid), 0);
    chk_eq("reset_tdata", sdata(), 0);
    en    = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Basic period: one sample every 18 cycles, one full turn in 16 samples
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wait_valid(40, n, seen);
      chk_eq("period_seen", seen, 1);
      chk_eq("period_gap", n, 18);
      chk_near("period_sine", sdata(), exp_sin[k], 16);
    end

    // Gain 2.0 with offset 1.0: peak saturates, trough lands at -1.0
    rst_n  = 1'b0;
    en     = 1'b0;
    gain   = 16'h8000;
    offset = 18'h10000;
    inc    = 16'h4000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    wait_valid(40, n, seen);
    chk_near("gain_ph0000", sdata(), 65536, 32);
    wait_valid(40, n, seen);
    chk_eq("gain_ph4000_sat", sdata(), 131071);
    wait_valid(40, n, seen);
    chk_near("gain_ph8000", sdata(), 65536, 32);
    wait_valid(40, n, seen);
    chk_near("gain_phC000", sdata(), -65536, 32);

    // Backpressure: beat holds, phase advances by one step only
    rst_n  = 1'b0;
    en     = 1'b0;
    gain   = 16'h4000;
    offset = 18'h00000;
    inc    = 16'h1000;
    tready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    wait_valid(40, n, seen);
    chk_eq("bp_first_gap", n, 18);
    chk_near("bp_first_data", sdata(), 0, 16);
    d0 = sdata();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_eq("bp_hold_tvalid", 32'(tvalid), 1);
      chk_eq("bp_hold_tdata", sdata(), d0);
    end
    tready = 1'b1;
    @(negedge clk);
    chk_eq("bp_accept_drop", 32'(tvalid), 0);
    wait_valid(40, n, seen);
    chk_eq("bp_next_gap", n, 17);
    chk_near("bp_next_data", sdata(), 25080, 16);

    // Disable at CALC cycle 5: sample is dropped, restart from phase 0
    offset = 18'h00123;
    repeat (5) @(negedge clk);
    en = 1'b0;
    wait_valid(30, n, seen);
    chk_eq("calc_abort_no_valid", seen, 0);
    en = 1'b1;
    wait_valid(40, n, seen);
    chk_eq("calc_abort_gap", n, 18);
    chk_near("calc_abort_restart", sdata(), 291, 16);

    // Disable while VALID: the beat completes, then the engine idles
    tready = 1'b0;
    en     = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_eq("valid_dis_hold", 32'(tvalid), 1);
    end
    tready = 1'b1;
    @(negedge clk);
    chk_eq("valid_dis_drop", 32'(tvalid), 0);
    wait_valid(30, n, seen);
    chk_eq("valid_dis_idle", seen, 0);
    en = 1'b1;
    wait_valid(40, n, seen);
    chk_eq("valid_dis_gap", n, 18);
    chk_near("valid_dis_restart", sdata(), 291, 16);

    // Async reset mid-CALC clears outputs without a clock edge
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk_eq("areset_calc_tvalid", 32'(tvalid), 0);
    chk_eq("areset_calc_tdata", sdata(), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    tready = 1'b0;
    @(negedge clk);
    en = 1'b1;
    wait_valid(40, n, seen);
    chk_eq("areset_calc_gap", n, 18);
    chk_near("areset_calc_restart", sdata(), 291, 16);

    // Async reset mid-VALID drops the held beat immediately
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk_eq("areset_valid_tvalid", 32'(tvalid), 0);
    chk_eq("areset_valid_tdata", sdata(), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    tready = 1'b1;
    @(negedge clk);
    en = 1'b1;
    wait_valid(40, n, seen);
    chk_eq("areset_valid_gap", n, 18);
    chk_near("areset_valid_restart", sdata(), 291, 16);
    wait_valid(40, n, seen);
    chk_near("areset_valid_second", sdata(), 25371, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
